// File: rtl/uart_fifo_int_ctrl.sv
// UART TX/RX byte FIFOs with status flags, RX timeout and prioritized interrupt ID.
// Zero-latency status: counts/flags register on the strobe edge; interrupt outputs decode those registers combinationally.
module uart_fifo_int_ctrl #(
    parameter int DEPTH         = 16,
    parameter int PTR_W         = 4,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic             apb_clk_in,
    input  logic             apb_rstn_in,
    input  logic             fifoen_in,
    input  logic             rxclr_in,
    input  logic             txclr_in,
    input  logic [1:0]       rxfiftl_in,
    input  logic             erbi_in,
    input  logic             etbei_in,
    input  logic             elsi_in,
    input  logic             edssi_in,
    input  logic             thr_wr_in,
    input  logic [7:0]       thr_data_in,
    input  logic             rbr_rd_in,
    output logic [7:0]       rbr_data_out,
    input  logic             iir_rd_in,
    input  logic             lsr_rd_in,
    input  logic             ms_int_in,
    input  logic             tx_pop_in,
    output logic [7:0]       tx_data_out,
    input  logic             tx_busy_in,
    input  logic             rx_push_in,
    input  logic [7:0]       rx_data_in,
    input  logic             char_tick_in,
    output logic [PTR_W:0]   rx_count_out,
    output logic [PTR_W:0]   tx_count_out,
    output logic             dr_out,
    output logic             thre_out,
    output logic             temt_out,
    output logic             oe_out,
    output logic [2:0]       intid_out,
    output logic             ipend_out
);
    localparam logic [PTR_W:0]   L_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   L_CNT1  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] L_PTR1  = PTR_W'(1);
    localparam logic [2:0]       L_TO    = 3'(TIMEOUT_CHARS);

    logic [7:0]       r_tx_mem [DEPTH];
    logic [7:0]       r_rx_mem [DEPTH];
    logic [PTR_W-1:0] r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
    logic [PTR_W:0]   r_tx_cnt, r_rx_cnt;
    logic             r_oe, r_thri, r_fifoen_q, r_etbei_q;
    logic [2:0]       r_to_cnt;

    logic [PTR_W:0]   w_eff_depth, w_trig;
    logic             w_fen_chg, w_tx_flush, w_rx_flush;
    logic             w_tx_full, w_rx_full, w_tx_wr, w_tx_pop, w_rx_push, w_rx_pop, w_rx_ovr;
    logic             w_tx_to_empty, w_etbei_rise, w_to_flag;

    // Single-byte (16450) mode behaves as a one-entry FIFO.
    assign w_eff_depth = fifoen_in ? L_DEPTH : L_CNT1;
    assign w_fen_chg   = fifoen_in ^ r_fifoen_q;
    assign w_tx_flush  = txclr_in | w_fen_chg;
    assign w_rx_flush  = rxclr_in | w_fen_chg;
    assign w_tx_full   = (r_tx_cnt >= w_eff_depth);
    assign w_rx_full   = (r_rx_cnt >= w_eff_depth);

    assign w_tx_wr   = thr_wr_in & ~w_tx_full & ~w_tx_flush;
    assign w_tx_pop  = tx_pop_in & (r_tx_cnt != '0) & ~w_tx_flush;
    assign w_rx_push = rx_push_in & ~w_rx_full & ~w_rx_flush;
    assign w_rx_ovr  = rx_push_in & w_rx_full & ~w_rx_flush;
    assign w_rx_pop  = rbr_rd_in & (r_rx_cnt != '0) & ~w_rx_flush;

    assign w_tx_to_empty = w_tx_pop & ~w_tx_wr & (r_tx_cnt == L_CNT1);
    assign w_etbei_rise  = etbei_in & ~r_etbei_q & (r_tx_cnt == '0);
    assign w_to_flag     = fifoen_in & (r_to_cnt == L_TO);

    always_ff @(posedge apb_clk_in) begin
        if (w_tx_wr) r_tx_mem[r_tx_wr] <= thr_data_in;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data_in;
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_wr)  r_tx_wr <= r_tx_wr + L_PTR1;
            if (w_tx_pop) r_tx_rd <= r_tx_rd + L_PTR1;
            if (w_tx_wr && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + L_CNT1;
            else if (!w_tx_wr && w_tx_pop) r_tx_cnt <= r_tx_cnt - L_CNT1;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else if (w_rx_flush) begin
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + L_PTR1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + L_PTR1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + L_CNT1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - L_CNT1;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_oe       <= 1'b0;
            r_thri     <= 1'b0;
            r_to_cnt   <= '0;
            r_fifoen_q <= 1'b0;
            r_etbei_q  <= 1'b0;
        end else begin
            r_fifoen_q <= fifoen_in;
            r_etbei_q  <= etbei_in;
            // A fresh overrun outranks the LSR read that would clear it.
            if (w_rx_ovr)       r_oe <= 1'b1;
            else if (lsr_rd_in) r_oe <= 1'b0;
            if (thr_wr_in)                                    r_thri <= 1'b0;
            else if (w_tx_to_empty || w_etbei_rise)           r_thri <= 1'b1;
            else if (iir_rd_in && !ipend_out && intid_out == 3'b001) r_thri <= 1'b0;
            if (!fifoen_in || rx_push_in || rbr_rd_in || w_rx_flush || r_rx_cnt == '0)
                r_to_cnt <= '0;
            else if (char_tick_in && r_to_cnt != L_TO)
                r_to_cnt <= r_to_cnt + 3'd1;
        end
    end

    always_comb begin
        w_trig = L_CNT1;
        if (fifoen_in) begin
            case (rxfiftl_in)
                2'd0:    w_trig = (PTR_W+1)'(1);
                2'd1:    w_trig = (PTR_W+1)'(4);
                2'd2:    w_trig = (PTR_W+1)'(8);
                default: w_trig = (PTR_W+1)'(14);
            endcase
        end
        intid_out = 3'b000;
        ipend_out = 1'b1;
        if (elsi_in && r_oe) begin
            intid_out = 3'b011;
            ipend_out = 1'b0;
        end else if (erbi_in && r_rx_cnt >= w_trig) begin
            intid_out = 3'b010;
            ipend_out = 1'b0;
        end else if (erbi_in && w_to_flag) begin
            intid_out = 3'b110;
            ipend_out = 1'b0;
        end else if (etbei_in && r_thri) begin
            intid_out = 3'b001;
            ipend_out = 1'b0;
        end else if (edssi_in && ms_int_in) begin
            intid_out = 3'b000;
            ipend_out = 1'b0;
        end
    end

    assign rx_count_out = r_rx_cnt;
    assign tx_count_out = r_tx_cnt;
    assign dr_out       = (r_rx_cnt != '0);
    assign thre_out     = (r_tx_cnt == '0);
    assign temt_out     = thre_out & ~tx_busy_in;
    assign oe_out       = r_oe;
    assign rbr_data_out = (r_rx_cnt == '0) ? 8'h00 : r_rx_mem[r_rx_rd];
    assign tx_data_out  = (r_tx_cnt == '0) ? 8'h00 : r_tx_mem[r_tx_rd];
endmodule
